// File: rtl/core_rot_pkg.sv
// Shared definitions for the rotate engine: sequencer states, angle/direction
// codes and tile geometry constants.
package core_rot_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CALC,
        RD_REQ,
        RD_WAIT,
        ROT_START,
        ROT_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    localparam logic [1:0] DEG_0   = 2'd0;
    localparam logic [1:0] DEG_90  = 2'd1;
    localparam logic [1:0] DEG_180 = 2'd2;
    localparam logic [1:0] DEG_270 = 2'd3;

    localparam logic CW  = 1'b0;
    localparam logic CCW = 1'b1;

    localparam int unsigned TILE_PIX   = 64;
    localparam int unsigned TILE_BYTES = 192;

    // Tile index counters, and tile-count registers (ceil(65535/8) = 8192 needs one more bit)
    localparam int unsigned CNT_W   = 13;
    localparam int unsigned TILES_W = 14;

    // Counter-clockwise turns are folded onto the equivalent clockwise angle
    function automatic logic [1:0] eff_angle(input logic direction, input logic [1:0] degrees);
        return (direction == CCW) ? 2'(2'd0 - degrees) : degrees;
    endfunction

endpackage

// File: rtl/core_tile_addr.sv
// Combinational tile address unit: maps the source tile (tx,ty) to its rotated
// destination tile and produces both tile base addresses and line strides.
module core_tile_addr
    import core_rot_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BPP       = 3,
    parameter int unsigned TILE_LOG2 = 3
) (
    input  logic [TILES_W-1:0] tw,
    input  logic [TILES_W-1:0] th,
    input  logic [CNT_W-1:0]   tx,
    input  logic [CNT_W-1:0]   ty,
    input  logic               direction,
    input  logic [1:0]         degrees,
    input  logic [ADDR_W-1:0]  src_base,
    input  logic [ADDR_W-1:0]  dst_base,
    output logic [ADDR_W-1:0]  src_addr,
    output logic [ADDR_W-1:0]  dst_addr,
    output logic [ADDR_W-1:0]  src_stride,
    output logic [ADDR_W-1:0]  dst_stride
);
    localparam int unsigned TILE_EDGE = 1 << TILE_LOG2;
    localparam logic [ADDR_W-1:0] TILE_ROW = ADDR_W'(TILE_EDGE * BPP);

    logic [1:0]         eff;
    logic [TILES_W-1:0] tx_w, ty_w, dx, dy, otw;

    assign eff  = eff_angle(direction, degrees);
    assign tx_w = TILES_W'(tx);
    assign ty_w = TILES_W'(ty);

    always_comb begin
        dx  = tx_w;
        dy  = ty_w;
        otw = tw;
        case (eff)
            DEG_90: begin
                dx  = th - TILES_W'(1) - ty_w;
                dy  = tx_w;
                otw = th;
            end
            DEG_180: begin
                dx  = tw - TILES_W'(1) - tx_w;
                dy  = th - TILES_W'(1) - ty_w;
                otw = tw;
            end
            DEG_270: begin
                dx  = ty_w;
                dy  = tw - TILES_W'(1) - tx_w;
                otw = th;
            end
            default: begin
                dx  = tx_w;
                dy  = ty_w;
                otw = tw;
            end
        endcase
    end

    // Strides use the tile-padded image width; all sums wrap modulo 2^ADDR_W
    assign src_stride = ADDR_W'(tw) * TILE_ROW;
    assign dst_stride = ADDR_W'(otw) * TILE_ROW;
    assign src_addr   = src_base + (ADDR_W'(ty_w) << TILE_LOG2) * src_stride + ADDR_W'(tx_w) * TILE_ROW;
    assign dst_addr   = dst_base + (ADDR_W'(dy) << TILE_LOG2) * dst_stride + ADDR_W'(dx) * TILE_ROW;

endmodule

// File: rtl/core_tile_sched.sv
// Tile sequencer for the rotate engine: walks the source image in raster tile
// order, running DMA read, core rotation and DMA write for each tile.
module core_tile_sched
    import core_rot_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BPP       = 3,
    parameter int unsigned TILE_LOG2 = 3
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET,
    input  logic              I_START,
    input  logic              I_ABORT,
    input  logic [15:0]       I_WIDTH,
    input  logic [15:0]       I_HEIGHT,
    input  logic              I_DIRECTION,
    input  logic [1:0]        I_DEGREES,
    input  logic [ADDR_W-1:0] I_SRC_BASE,
    input  logic [ADDR_W-1:0] I_DST_BASE,
    input  logic              I_DMA_ACK,
    input  logic              I_DMA_DONE,
    input  logic              I_CORE_DONE,
    output logic              O_DMA_RD_REQ,
    output logic              O_DMA_WR_REQ,
    output logic [ADDR_W-1:0] O_SRC_ADDR,
    output logic [ADDR_W-1:0] O_DST_ADDR,
    output logic [ADDR_W-1:0] O_SRC_STRIDE,
    output logic [ADDR_W-1:0] O_DST_STRIDE,
    output logic              O_CORE_START,
    output logic              O_CORE_DIRECTION,
    output logic [1:0]        O_CORE_DEGREES,
    output logic              O_BUSY,
    output logic              O_DONE
);
    localparam int unsigned TILE_EDGE = 1 << TILE_LOG2;

    state_t             state;
    logic [TILES_W-1:0] tw, th;
    logic [CNT_W-1:0]   tx, ty;
    logic [ADDR_W-1:0]  src_base, dst_base;
    logic [ADDR_W-1:0]  calc_src, calc_dst, calc_src_stride, calc_dst_stride;
    logic               done_held;
    logic               last_col, last_row;

    core_tile_addr #(
        .ADDR_W   (ADDR_W),
        .BPP      (BPP),
        .TILE_LOG2(TILE_LOG2)
    ) u_addr (
        .tw        (tw),
        .th        (th),
        .tx        (tx),
        .ty        (ty),
        .direction (O_CORE_DIRECTION),
        .degrees   (O_CORE_DEGREES),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .src_addr  (calc_src),
        .dst_addr  (calc_dst),
        .src_stride(calc_src_stride),
        .dst_stride(calc_dst_stride)
    );

    assign last_col = ({1'b0, tx} == tw - TILES_W'(1));
    assign last_row = ({1'b0, ty} == th - TILES_W'(1));

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state            <= IDLE;
            tw               <= '0;
            th               <= '0;
            tx               <= '0;
            ty               <= '0;
            src_base         <= '0;
            dst_base         <= '0;
            done_held        <= 1'b0;
            O_DMA_RD_REQ     <= 1'b0;
            O_DMA_WR_REQ     <= 1'b0;
            O_SRC_ADDR       <= '0;
            O_DST_ADDR       <= '0;
            O_SRC_STRIDE     <= '0;
            O_DST_STRIDE     <= '0;
            O_CORE_START     <= 1'b0;
            O_CORE_DIRECTION <= 1'b0;
            O_CORE_DEGREES   <= '0;
            O_BUSY           <= 1'b0;
            O_DONE           <= 1'b0;
        end else begin
            O_CORE_START <= 1'b0;
            O_DONE       <= 1'b0;
            if (state != IDLE && I_ABORT) begin
                state        <= IDLE;
                O_DMA_RD_REQ <= 1'b0;
                O_DMA_WR_REQ <= 1'b0;
                O_BUSY       <= 1'b0;
                done_held    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (I_START && !I_ABORT) begin
                            tw               <= TILES_W'(({1'b0, I_WIDTH} + 17'(TILE_EDGE - 1)) >> TILE_LOG2);
                            th               <= TILES_W'(({1'b0, I_HEIGHT} + 17'(TILE_EDGE - 1)) >> TILE_LOG2);
                            tx               <= '0;
                            ty               <= '0;
                            src_base         <= I_SRC_BASE;
                            dst_base         <= I_DST_BASE;
                            O_CORE_DIRECTION <= I_DIRECTION;
                            O_CORE_DEGREES   <= I_DEGREES;
                            done_held        <= 1'b0;
                            O_BUSY           <= 1'b1;
                            state            <= (I_WIDTH == '0 || I_HEIGHT == '0) ? DONE : CALC;
                        end
                    end
                    CALC: begin
                        O_SRC_ADDR   <= calc_src;
                        O_DST_ADDR   <= calc_dst;
                        O_SRC_STRIDE <= calc_src_stride;
                        O_DST_STRIDE <= calc_dst_stride;
                        O_DMA_RD_REQ <= 1'b1;
                        state        <= RD_REQ;
                    end
                    // A burst-done arriving together with the ack is remembered for the wait state
                    RD_REQ: begin
                        if (I_DMA_ACK) begin
                            O_DMA_RD_REQ <= 1'b0;
                            done_held    <= I_DMA_DONE;
                            state        <= RD_WAIT;
                        end
                    end
                    RD_WAIT: begin
                        if (I_DMA_DONE || done_held) begin
                            done_held    <= 1'b0;
                            O_CORE_START <= 1'b1;
                            state        <= ROT_START;
                        end
                    end
                    ROT_START: state <= ROT_WAIT;
                    ROT_WAIT: begin
                        if (I_CORE_DONE) begin
                            O_DMA_WR_REQ <= 1'b1;
                            state        <= WR_REQ;
                        end
                    end
                    WR_REQ: begin
                        if (I_DMA_ACK) begin
                            O_DMA_WR_REQ <= 1'b0;
                            done_held    <= I_DMA_DONE;
                            state        <= WR_WAIT;
                        end
                    end
                    WR_WAIT: begin
                        if (I_DMA_DONE || done_held) begin
                            done_held <= 1'b0;
                            if (last_col && last_row) begin
                                state <= DONE;
                            end else if (last_col) begin
                                tx    <= '0;
                                ty    <= ty + CNT_W'(1);
                                state <= CALC;
                            end else begin
                                tx    <= tx + CNT_W'(1);
                                state <= CALC;
                            end
                        end
                    end
                    DONE: begin
                        O_DONE <= 1'b1;
                        O_BUSY <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_core_tile_sched.sv
// Bench for core_tile_sched: DMA/core responder, table vectors, corner sequences
// and random jobs checked against a grid-rotation reference model.
module tb_core_tile_sched;
    localparam int BUDGET = 4000;

    logic        clk = 1'b0;
    logic        I_HRESET = 1'b1, I_START = 1'b0, I_ABORT = 1'b0;
    logic [15:0] I_WIDTH = '0, I_HEIGHT = '0;
    logic        I_DIRECTION = 1'b0;
    logic [1:0]  I_DEGREES = '0;
    logic [31:0] I_SRC_BASE = '0, I_DST_BASE = '0;
    logic        I_DMA_ACK = 1'b0, I_DMA_DONE = 1'b0, I_CORE_DONE = 1'b0;
    logic        O_DMA_RD_REQ, O_DMA_WR_REQ, O_CORE_START, O_CORE_DIRECTION, O_BUSY, O_DONE;
    logic [31:0] O_SRC_ADDR, O_DST_ADDR, O_SRC_STRIDE, O_DST_STRIDE;
    logic [1:0]  O_CORE_DEGREES;

    always #5 clk = ~clk;

    core_tile_sched #(.ADDR_W(32), .BPP(3), .TILE_LOG2(3)) dut (
        .I_HCLK(clk), .I_HRESET(I_HRESET), .I_START(I_START), .I_ABORT(I_ABORT),
        .I_WIDTH(I_WIDTH), .I_HEIGHT(I_HEIGHT), .I_DIRECTION(I_DIRECTION), .I_DEGREES(I_DEGREES),
        .I_SRC_BASE(I_SRC_BASE), .I_DST_BASE(I_DST_BASE), .I_DMA_ACK(I_DMA_ACK),
        .I_DMA_DONE(I_DMA_DONE), .I_CORE_DONE(I_CORE_DONE), .O_DMA_RD_REQ(O_DMA_RD_REQ),
        .O_DMA_WR_REQ(O_DMA_WR_REQ), .O_SRC_ADDR(O_SRC_ADDR), .O_DST_ADDR(O_DST_ADDR),
        .O_SRC_STRIDE(O_SRC_STRIDE), .O_DST_STRIDE(O_DST_STRIDE), .O_CORE_START(O_CORE_START),
        .O_CORE_DIRECTION(O_CORE_DIRECTION), .O_CORE_DEGREES(O_CORE_DEGREES),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE)
    );

    typedef struct {
        logic [31:0] src, dst, sstr, dstr;
        logic        dir;
        logic [1:0]  deg;
    } tile_t;

    typedef struct {
        int w, h;
        bit dir;
        int deg, ack;
        bit coin;
        int ntiles;
        logic [31:0] src0, dst0, srcl, dstl, sstr, dstr;
    } vec_t;

    tile_t obs_q[$], exp_q[$];
    int    req_hist[$];
    int    n_cmp = 0, n_err = 0;
    int    cs_cnt, req_total, done_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: destination tile found by turning the tile grid clockwise one quarter at a time
    function automatic void build_model(int w, int h, bit dir, int deg, logic [31:0] sb, logic [31:0] db);
        int tw, th, q, x, y, gw, gh, t;
        longint sstr;
        tw = (w + 7) / 8;
        th = (h + 7) / 8;
        q = dir ? (4 - deg) % 4 : deg;
        sstr = longint'(tw) * 24;
        exp_q.delete();
        for (int ty = 0; ty < th; ty++) begin
            for (int tx = 0; tx < tw; tx++) begin
                x = tx; y = ty; gw = tw; gh = th;
                for (int r = 0; r < q; r++) begin
                    t = x; x = gh - 1 - y; y = t;
                    t = gw; gw = gh; gh = t;
                end
                exp_q.push_back('{32'(longint'(sb) + longint'(ty) * 8 * sstr + longint'(tx) * 24),
                                  32'(longint'(db) + longint'(y) * 8 * longint'(gw) * 24 + longint'(x) * 24),
                                  32'(sstr), 32'(gw * 24), dir, 2'(deg)});
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        chk({tag, ":ntiles"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s:addr[%0d]", tag, i), {obs_q[i].src, obs_q[i].dst}, {exp_q[i].src, exp_q[i].dst});
            chk($sformatf("%s:stride[%0d]", tag, i), {obs_q[i].sstr, obs_q[i].dstr}, {exp_q[i].sstr, exp_q[i].dstr});
            chk($sformatf("%s:dirdeg[%0d]", tag, i), 64'({obs_q[i].dir, obs_q[i].deg}), 64'({exp_q[i].dir, exp_q[i].deg}));
        end
    endtask

    // Starts a job and plays DMA/core; returns after O_DONE or at the ROT_START of tile abort_tile
    task automatic run_job(input int w, input int h, input bit dir, input int deg,
                           input logic [31:0] sb, input logic [31:0] db,
                           input int ack_dly, input bit coin, input int abort_tile);
        int req_run, dma_cd, core_cd;
        bit ended;
        req_run = 0; dma_cd = 0; core_cd = 0; ended = 1'b0;
        obs_q.delete(); req_hist.delete();
        cs_cnt = 0; req_total = 0; done_cnt = 0;
        I_WIDTH = 16'(w); I_HEIGHT = 16'(h); I_DIRECTION = dir; I_DEGREES = 2'(deg);
        I_SRC_BASE = sb; I_DST_BASE = db; I_START = 1'b1;
        tick();
        I_START = 1'b0;
        chk("busy_n+1", 64'(O_BUSY), 64'(1));
        chk("rdreq_n+1", 64'(O_DMA_RD_REQ), 64'(0));
        for (int c = 0; c < BUDGET && !ended; c++) begin
            tick();
            I_DMA_ACK = 1'b0; I_DMA_DONE = 1'b0; I_CORE_DONE = 1'b0;
            if (c == 0) begin
                chk("rdreq_n+2", 64'(O_DMA_RD_REQ), 64'(w != 0 && h != 0));
                chk("done_n+2", 64'(O_DONE), 64'(w == 0 || h == 0));
            end
            if (O_DONE) begin
                done_cnt++;
                chk("busy_at_done", 64'(O_BUSY), 64'(0));
                ended = 1'b1;
            end else if (O_CORE_START) begin
                cs_cnt++;
                if (cs_cnt == abort_tile + 1) ended = 1'b1;
                else core_cd = $urandom_range(1, 4);
            end else if (core_cd > 0) begin
                core_cd--;
                if (core_cd == 0) I_CORE_DONE = 1'b1;
                else if ($urandom_range(0, 3) == 0) I_DMA_DONE = 1'b1;
            end else if (O_DMA_RD_REQ || O_DMA_WR_REQ) begin
                if (req_run == 0 && O_DMA_RD_REQ)
                    obs_q.push_back('{O_SRC_ADDR, O_DST_ADDR, O_SRC_STRIDE, O_DST_STRIDE,
                                      O_CORE_DIRECTION, O_CORE_DEGREES});
                req_run++;
                req_total++;
                if (O_DMA_RD_REQ && $urandom_range(0, 3) == 0) I_CORE_DONE = 1'b1;
                if (req_run >= ack_dly) begin
                    I_DMA_ACK = 1'b1;
                    req_hist.push_back(req_run);
                    req_run = 0;
                    if (coin) I_DMA_DONE = 1'b1;
                    else dma_cd = $urandom_range(1, 4);
                end
            end else if (dma_cd > 0) begin
                dma_cd--;
                if (dma_cd == 0) I_DMA_DONE = 1'b1;
            end
        end
        I_DMA_ACK = 1'b0; I_DMA_DONE = 1'b0; I_CORE_DONE = 1'b0;
        chk("job_end", 64'(ended), 64'(1));
        if (abort_tile < 0) begin
            for (int k = 0; k < 2; k++) begin
                tick();
                if (O_DONE) done_cnt++;
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int   w, h, deg, ack;
        bit   dir, coin;
        logic [31:0] sb, db;

        vt[0] = '{16, 8, 1'b0, 1, 1, 1'b0, 2, 32'h1000, 32'h2000, 32'h1018, 32'h20C0, 32'd48, 32'd24};
        vt[1] = '{16, 8, 1'b1, 1, 5, 1'b0, 2, 32'h1000, 32'h20C0, 32'h1018, 32'h2000, 32'd48, 32'd24};
        vt[2] = '{16, 16, 1'b0, 2, 2, 1'b1, 4, 32'h1000, 32'h2198, 32'h1198, 32'h2000, 32'd48, 32'd48};
        vt[3] = '{10, 5, 1'b0, 0, 1, 1'b1, 2, 32'h1000, 32'h2000, 32'h1018, 32'h2018, 32'd48, 32'd48};
        vt[4] = '{0, 5, 1'b0, 0, 1, 1'b0, 0, '0, '0, '0, '0, '0, '0};
        vt[5] = '{7, 0, 1'b1, 3, 1, 1'b0, 0, '0, '0, '0, '0, '0, '0};

        repeat (3) tick();
        chk("rst_ctrl", 64'({O_DMA_RD_REQ, O_DMA_WR_REQ, O_CORE_START, O_BUSY, O_DONE, O_CORE_DIRECTION, O_CORE_DEGREES}), 64'(0));
        chk("rst_addr", {O_SRC_ADDR, O_DST_ADDR}, 64'(0));
        chk("rst_stride", {O_SRC_STRIDE, O_DST_STRIDE}, 64'(0));
        I_HRESET = 1'b0;
        tick();

        foreach (vt[i]) begin
            run_job(vt[i].w, vt[i].h, vt[i].dir, vt[i].deg, 32'h1000, 32'h2000, vt[i].ack, vt[i].coin, -1);
            chk($sformatf("vec%0d:ntiles", i), 64'(obs_q.size()), 64'(vt[i].ntiles));
            chk($sformatf("vec%0d:done_cnt", i), 64'(done_cnt), 64'(1));
            chk($sformatf("vec%0d:core_starts", i), 64'(cs_cnt), 64'(vt[i].ntiles));
            if (vt[i].ntiles == 0) begin
                chk($sformatf("vec%0d:no_req", i), 64'(req_total), 64'(0));
            end else if (obs_q.size() > 0) begin
                chk($sformatf("vec%0d:first", i), {obs_q[0].src, obs_q[0].dst}, {vt[i].src0, vt[i].dst0});
                chk($sformatf("vec%0d:last", i), {obs_q[obs_q.size()-1].src, obs_q[obs_q.size()-1].dst}, {vt[i].srcl, vt[i].dstl});
                chk($sformatf("vec%0d:strides", i), {obs_q[0].sstr, obs_q[0].dstr}, {vt[i].sstr, vt[i].dstr});
                chk($sformatf("vec%0d:dirdeg", i), 64'({obs_q[0].dir, obs_q[0].deg}), 64'({vt[i].dir, 2'(vt[i].deg)}));
            end
            foreach (req_hist[j])
                chk($sformatf("vec%0d:req_len[%0d]", i, j), 64'(req_hist[j]), 64'(vt[i].ack));
            build_model(vt[i].w, vt[i].h, vt[i].dir, vt[i].deg, 32'h1000, 32'h2000);
            compare_model($sformatf("vec%0d", i));
        end

        // Abort in ROT_WAIT together with a core-done: abort wins, no done pulse
        run_job(16, 16, 1'b0, 2, 32'h1000, 32'h2000, 1, 1'b0, 1);
        chk("abort:core_start", 64'(O_CORE_START), 64'(1));
        tick();
        I_ABORT = 1'b1; I_CORE_DONE = 1'b1;
        tick();
        I_ABORT = 1'b0; I_CORE_DONE = 1'b0;
        chk("abort:cleared", 64'({O_BUSY, O_DMA_RD_REQ, O_DMA_WR_REQ, O_CORE_START, O_DONE}), 64'(0));
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (O_DONE || O_BUSY) done_cnt++;
        end
        chk("abort:quiet", 64'(done_cnt), 64'(0));
        run_job(16, 16, 1'b0, 2, 32'h1000, 32'h2000, 1, 1'b0, -1);
        chk("restart:done_cnt", 64'(done_cnt), 64'(1));
        build_model(16, 16, 1'b0, 2, 32'h1000, 32'h2000);
        compare_model("restart");

        // Reset in the middle of a job behaves like power-up reset
        run_job(20, 12, 1'b1, 3, 32'hDEAD0000, 32'hBEEF0000, 2, 1'b0, 0);
        I_HRESET = 1'b1;
        tick();
        chk("midrst_ctrl", 64'({O_DMA_RD_REQ, O_DMA_WR_REQ, O_CORE_START, O_BUSY, O_DONE, O_CORE_DIRECTION, O_CORE_DEGREES}), 64'(0));
        chk("midrst_addr", {O_SRC_ADDR, O_DST_ADDR}, 64'(0));
        chk("midrst_stride", {O_SRC_STRIDE, O_DST_STRIDE}, 64'(0));
        I_HRESET = 1'b0;
        tick();

        for (int k = 0; k < 16; k++) begin
            w = $urandom_range(0, 40);
            h = $urandom_range(1, 40);
            dir = 1'($urandom_range(0, 1));
            deg = $urandom_range(0, 3);
            ack = $urandom_range(1, 3);
            coin = 1'($urandom_range(0, 1));
            sb = $urandom;
            db = $urandom;
            run_job(w, h, dir, deg, sb, db, ack, coin, -1);
            chk($sformatf("rnd%0d:done_cnt", k), 64'(done_cnt), 64'(1));
            build_model(w, h, dir, deg, sb, db);
            compare_model($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_tile_sched.md
Name: core_tile_sched

Overview:
- Top-level sequencer for the rotate engine. It walks the source image in 8x8-pixel tiles (64 pixels, 192 bytes RGB) in raster order.
- For each tile it runs one DMA read burst into the input buffer, then one rotation pass of the pixel address core, then one DMA write burst from the output buffer.
- It computes source and rotated-destination tile base addresses. It sits between the register block (core_set) and the DMA / pixel core.

Parameters:
- ADDR_W, 32, width of source/destination byte addresses.
- BPP, 3, bytes per pixel (R,G,B).
- TILE_LOG2, 3, tile edge = 2^TILE_LOG2 pixels; fixed at 3 for this design.

Ports:
- I_HCLK  in  1  clock; all logic on rising edge.
- I_HRESET  in  1  synchronous, active-high reset.
- I_START  in  1  start pulse; sampled only in IDLE.
- I_ABORT  in  1  abandon current job.
- I_WIDTH  in  16  source width, pixels.
- I_HEIGHT  in  16  source height, pixels.
- I_DIRECTION  in  1  1 = counter-clockwise, 0 = clockwise.
- I_DEGREES  in  2  0=0, 1=90, 2=180, 3=270 degrees.
- I_SRC_BASE  in  ADDR_W  source image byte base.
- I_DST_BASE  in  ADDR_W  destination image byte base.
- I_DMA_ACK  in  1  DMA accepted the current request.
- I_DMA_DONE  in  1  DMA burst complete (1-cycle pulse).
- I_CORE_DONE  in  1  pixel core finished the tile (1-cycle pulse).
- O_DMA_RD_REQ  out  1  read-burst request, level.
- O_DMA_WR_REQ  out  1  write-burst request, level.
- O_SRC_ADDR  out  ADDR_W  current source tile base.
- O_DST_ADDR  out  ADDR_W  current destination tile base.
- O_SRC_STRIDE  out  ADDR_W  source line stride, bytes.
- O_DST_STRIDE  out  ADDR_W  destination line stride, bytes.
- O_CORE_START  out  1  1-cycle start pulse to pixel core.
- O_CORE_DIRECTION  out  1  latched direction for the core.
- O_CORE_DEGREES  out  2  latched degrees for the core.
- O_BUSY  out  1  high in every state except IDLE.
- O_DONE  out  1  1-cycle pulse when the job completes.

Behaviour:
- Reset: state IDLE; every output 0; tile counters tx=ty=0.
- All outputs are registered.
- IDLE, I_START=1 (I_ABORT=0): latch W, H, bases, direction and degrees.
  - TW=ceil(W/8), TH=ceil(H/8).
  - If W==0 or H==0, go to DONE. Otherwise go to CALC.
  - I_START outside IDLE is ignored.
- Effective clockwise angle: eff = DIRECTION ? (4-DEGREES) mod 4 : DEGREES. Thus CCW90 == CW270.
- Output tile grid width OTW: TW for eff 0/180, TH for eff 90/270. Strides use padded dimensions:
  - SRC_STRIDE = TW*8*BPP.
  - DST_STRIDE = OTW*8*BPP.
- Destination tile (dx,dy):
  - eff0: (tx,ty).
  - eff90: (TH-1-ty, tx).
  - eff180: (TW-1-tx, TH-1-ty).
  - eff270: (ty, TW-1-tx).
- Tile addresses, computed modulo 2^ADDR_W:
  - SRC = SRC_BASE + ty*8*SRC_STRIDE + tx*8*BPP.
  - DST = DST_BASE + dy*8*DST_STRIDE + dx*8*BPP.
- CALC (1 cycle): register O_SRC_ADDR, O_DST_ADDR and strides, then go to RD_REQ. Addresses are stable from RD_REQ through WR_WAIT.
- RD_REQ: O_DMA_RD_REQ=1 until the cycle I_DMA_ACK=1. The request drops the next cycle; go to RD_WAIT.
- RD_WAIT: on I_DMA_DONE, go to ROT_START. A DONE arriving in the same cycle as ACK is held and honoured.
- ROT_START: O_CORE_START=1 for exactly one cycle, then ROT_WAIT.
- ROT_WAIT: on I_CORE_DONE, go to WR_REQ.
- WR_REQ / WR_WAIT: mirror RD_REQ / RD_WAIT using O_DMA_WR_REQ.
- WR_WAIT on I_DMA_DONE:
  - If tx==TW-1 and ty==TH-1, go to DONE.
  - Else if tx==TW-1: tx=0, ty=ty+1, go to CALC.
  - Else: tx=tx+1, go to CALC.
- DONE: O_DONE=1 for one cycle; go to IDLE.
- Latency: I_START at cycle n gives O_BUSY=1 at n+1 and O_DMA_RD_REQ=1 at n+2.
- I_ABORT in any non-IDLE state: next cycle go to IDLE with all requests, start and O_BUSY cleared. O_DONE is not pulsed. I_ABORT has priority over every other event, including an I_DMA_DONE or I_CORE_DONE in the same cycle.
- I_HRESET mid-job: identical to power-up reset, taking effect on the next edge.
- Spurious I_DMA_DONE or I_CORE_DONE outside its wait state: ignored.
- Tile counters are 13 bits (ceil(65535/8)=8192). Multiplies may be spread over CALC only; CALC is exactly 1 cycle.

Decomposition:
- Shared package core_rot_pkg holds:
  - state encoding (IDLE, CALC, RD_REQ, RD_WAIT, ROT_START, ROT_WAIT, WR_REQ, WR_WAIT, DONE);
  - degree constants DEG_0..DEG_270;
  - direction constants CW=0, CCW=1;
  - TILE_PIX=64, TILE_BYTES=192.
- One sub-module, core_tile_addr: combinational eff/dx/dy/stride/address computation, registered by the FSM in CALC.

Test Plan:
- W=16,H=8, CW90, src 0x1000, dst 0x2000 -> 2 tiles:
  - tile0: SRC 0x1000, DST 0x2000;
  - tile1: SRC 0x1018, DST 0x20C0;
  - SRC_STRIDE 48, DST_STRIDE 24; O_DONE once.
- W=16,H=8, CCW90 (== CW270):
  - tile0: DST 0x20C0;
  - tile1: DST 0x2000;
  - O_CORE_DEGREES=1, O_CORE_DIRECTION=1.
- W=16,H=16, CW180 -> tile(0,0): DST 0x2000+0x198; tile(1,1): DST 0x2000; 4 tiles total, raster order.
- W=10,H=5, CW0 -> TW=2, TH=1; SRC_STRIDE 48; tile1: SRC 0x1018, DST 0x2018; W=0 -> O_DONE at n+2 with no DMA request.
- Handshake stress:
  - ACK delayed 5 cycles -> RD_REQ held 5 cycles;
  - DONE coincident with ACK -> accepted;
  - ABORT during ROT_WAIT -> IDLE next cycle, no O_DONE;
  - a new I_START then restarts from tile (0,0).
